// File: rtl/legv8_pkg.sv
// LEGv8 instruction-format definitions shared by the encoder slice:
// format codes, immediate field widths, reference opcodes and the fit helper.
package legv8_pkg;

   typedef enum logic [2:0] {
      FMT_R  = 3'd0,
      FMT_D  = 3'd1,
      FMT_I  = 3'd2,
      FMT_CB = 3'd3,
      FMT_B  = 3'd4
   } fmt_e;

   localparam int unsigned IMM_W_R  = 6;
   localparam int unsigned IMM_W_D  = 9;
   localparam int unsigned IMM_W_I  = 12;
   localparam int unsigned IMM_W_CB = 19;
   localparam int unsigned IMM_W_B  = 26;

   localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
   localparam logic [10:0] OP_LDUR  = 11'b11111000010;
   localparam logic [10:0] OP_STUR  = 11'b11111000000;
   localparam logic [5:0]  OP_B     = 6'b000101;
   localparam logic [7:0]  OP_CBZ   = 8'b10110100;
   localparam logic [7:0]  OP_BCOND = 8'b01010100;

   // True when v is the sign extension of its low n bits: bits [63:n-1] all equal.
   function automatic logic sext_fits(input logic [63:0] v, input int unsigned n);
      logic [63:0] upper_mask;
      logic [63:0] upper;
      upper_mask = '1 << (n - 1);
      upper      = v & upper_mask;
      return (upper == '0) || (upper == upper_mask);
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/word stream bundle between an instruction producer and the encoder.
interface instr_encoder_if #(
   parameter int unsigned ADDR_W = 10
);
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_fmt;
   logic [10:0]       in_opcode;
   logic [4:0]        in_rd;
   logic [4:0]        in_rn;
   logic [4:0]        in_rm;
   logic [63:0]       in_imm;

   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [ADDR_W-1:0] out_addr;

   modport master (
      output in_valid, in_fmt, in_opcode, in_rd, in_rn, in_rm, in_imm,
      input  in_ready,
      input  out_valid, out_instr, out_addr,
      output out_ready
   );

   modport slave (
      input  in_valid, in_fmt, in_opcode, in_rd, in_rn, in_rm, in_imm,
      output in_ready,
      output out_valid, out_instr, out_addr,
      input  out_ready
   );
endinterface

// File: rtl/imm_fit_check.sv
// Checks that a signed immediate survives truncation to its format's field
// and returns the truncated field, right-aligned.
module imm_fit_check
   import legv8_pkg::*;
(
   input  logic [63:0] imm,
   input  logic [2:0]  fmt,
   output logic        fits,
   output logic [25:0] field
);

   always_comb begin
      fits  = 1'b0;
      field = '0;
      case (fmt)
         FMT_R:  begin fits = sext_fits(imm, IMM_W_R);  field = {20'd0, imm[5:0]};  end
         FMT_D:  begin fits = sext_fits(imm, IMM_W_D);  field = {17'd0, imm[8:0]};  end
         FMT_I:  begin fits = sext_fits(imm, IMM_W_I);  field = {14'd0, imm[11:0]}; end
         FMT_CB: begin fits = sext_fits(imm, IMM_W_CB); field = {7'd0, imm[18:0]};  end
         FMT_B:  begin fits = sext_fits(imm, IMM_W_B);  field = imm[25:0];          end
         default: ;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Packs LEGv8 fields into 32-bit words and streams them with sequential byte
// addresses; out-of-range immediates and illegal formats are dropped and flagged.
module instr_encoder
   import legv8_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              base_load,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              clear_err,
   output logic              err_sticky,
   instr_encoder_if.slave    bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ENC  = 2'd1,
      S_OUT  = 2'd2
   } state_e;

   state_e            state, state_nxt;
   logic              in_ready, accept, load_out, drop, retire;

   logic [2:0]        req_fmt;
   logic [10:0]       req_op;
   logic [4:0]        req_rd, req_rn, req_rm;
   logic [63:0]       req_imm;

   logic              fits, legal;
   logic [25:0]       field;
   logic [31:0]       enc_word;

   logic [ADDR_W-1:0] counter, pend_addr, base_aligned;
   logic              pend_load;
   logic [31:0]       out_instr_q;
   logic [ADDR_W-1:0] out_addr_q;

   assign base_aligned  = {base_addr[ADDR_W-1:2], 2'b00};
   assign legal         = (req_fmt <= 3'(FMT_B));
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state == S_OUT);
   assign bus.out_instr = out_instr_q;
   assign bus.out_addr  = out_addr_q;

   imm_fit_check u_fit (
      .imm   (req_imm),
      .fmt   (req_fmt),
      .fits  (fits),
      .field (field)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      accept    = 1'b0;
      load_out  = 1'b0;
      drop      = 1'b0;
      retire    = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               accept    = 1'b1;
               state_nxt = S_ENC;
            end
         end
         S_ENC: begin
            if (fits && legal) begin
               load_out  = 1'b1;
               state_nxt = S_OUT;
            end else begin
               drop      = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_OUT: begin
            // skid: a new request may enter in the cycle the held word retires
            in_ready = bus.out_ready;
            if (bus.out_ready) begin
               retire = 1'b1;
               if (bus.in_valid) begin
                  accept    = 1'b1;
                  state_nxt = S_ENC;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      enc_word = '0;
      case (req_fmt)
         FMT_R:  enc_word = {req_op, req_rm, field[5:0], req_rn, req_rd};
         FMT_D:  enc_word = {req_op, field[8:0], 2'b00, req_rn, req_rd};
         FMT_I:  enc_word = {req_op[9:0], field[11:0], req_rn, req_rd};
         FMT_CB: enc_word = {req_op[7:0], field[18:0], req_rd};
         FMT_B:  enc_word = {req_op[5:0], field[25:0]};
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_fmt <= '0;
         req_op  <= '0;
         req_rd  <= '0;
         req_rn  <= '0;
         req_rm  <= '0;
         req_imm <= '0;
      end else if (accept) begin
         req_fmt <= bus.in_fmt;
         req_op  <= bus.in_opcode;
         req_rd  <= bus.in_rd;
         req_rn  <= bus.in_rn;
         req_rm  <= bus.in_rm;
         req_imm <= bus.in_imm;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         counter   <= '0;
         pend_load <= 1'b0;
         pend_addr <= '0;
      end else if (state == S_OUT || load_out) begin
         // a word already owns the current address: hold any base load until it retires
         if (retire) begin
            pend_load <= 1'b0;
            if (base_load && !accept) counter <= base_aligned;
            else if (pend_load)       counter <= pend_addr;
            else                      counter <= counter + ADDR_W'(4);
         end else if (base_load) begin
            pend_load <= 1'b1;
            pend_addr <= base_aligned;
         end
      end else if (base_load && !accept) begin
         counter <= base_aligned;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_instr_q <= '0;
         out_addr_q  <= '0;
      end else if (load_out) begin
         out_instr_q <= enc_word;
         out_addr_q  <= counter;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)          err_sticky <= 1'b0;
      else if (drop)      err_sticky <= 1'b1;
      else if (clear_err) err_sticky <= 1'b0;
   end

endmodule
